// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: FSM state encoding, default
// bundle widths and the word-alignment helper.
package mem_access_stage_pkg;

    localparam int DW_DEF = 32;
    localparam int RW_DEF = 5;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    function automatic logic is_word_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Bus wait-cycle counter: cleared when no wait is in progress, counts wait
// cycles while enabled and flags the last permitted wait cycle.
module mem_timeout_ctr #(
    parameter int TIMEOUT = 16,
    parameter int CW      = $clog2(TIMEOUT)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: runs loads/stores over a req/ack data bus, stalls EX/MEM
// while a transaction is outstanding and registers the MEM/WB bundle.
//
//   state | meaning
//   IDLE  | accepting EX/MEM bundles; non-memory ops pass straight to MEM/WB
//   REQ   | bus request outstanding, waiting for dmem_ack or timeout
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int RW      = RW_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_in,
    input  logic [DW-1:0] alu_result,
    input  logic [DW-1:0] store_data,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic          mem_to_reg_in,
    input  logic          reg_write_in,
    input  logic [RW-1:0] rd_in,
    output logic          stall,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [DW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic [DW-1:0] dmem_rdata,
    input  logic          dmem_ack,
    output logic          wb_valid,
    output logic [DW-1:0] wb_data,
    output logic [DW-1:0] wb_dir,
    output logic          wb_mem_to_reg,
    output logic          wb_reg_write,
    output logic [RW-1:0] wb_rd,
    output logic          exc_misalign,
    output logic          exc_bus
);

    logic [0:0]    state_q, state_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;

    logic [DW-1:0] hold_dir_q, hold_dir_d;
    logic          hold_load_q, hold_load_d;
    logic          hold_m2r_q, hold_m2r_d;
    logic          hold_rw_q, hold_rw_d;
    logic [RW-1:0] hold_rd_q, hold_rd_d;

    logic          wb_valid_q, wb_valid_d;
    logic [DW-1:0] wb_data_q, wb_data_d;
    logic [DW-1:0] wb_dir_q, wb_dir_d;
    logic          wb_m2r_q, wb_m2r_d;
    logic          wb_rw_q, wb_rw_d;
    logic [RW-1:0] wb_rd_q, wb_rd_d;
    logic          mis_q, mis_d;
    logic          bus_q, bus_d;

    logic memop;
    logic aligned;
    logic accept;
    logic in_req;
    logic tc;

    assign memop   = valid_in && (mem_read || mem_write);
    assign aligned = is_word_aligned(alu_result[1:0]);
    assign accept  = (state_q == ST_IDLE) && memop && aligned;
    assign in_req  = (state_q == ST_REQ);
    // The final wait cycle releases upstream so the next bundle lines up with IDLE.
    assign stall   = accept || (in_req && !dmem_ack && !tc);

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk (clk),
        .rst (rst),
        .clr (!in_req || dmem_ack || tc),
        .en  (in_req),
        .tc  (tc)
    );

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        hold_dir_d  = hold_dir_q;
        hold_load_d = hold_load_q;
        hold_m2r_d  = hold_m2r_q;
        hold_rw_d   = hold_rw_q;
        hold_rd_d   = hold_rd_q;
        wb_valid_d  = 1'b0;
        wb_data_d   = wb_data_q;
        wb_dir_d    = wb_dir_q;
        wb_m2r_d    = wb_m2r_q;
        wb_rw_d     = wb_rw_q;
        wb_rd_d     = wb_rd_q;
        mis_d       = 1'b0;
        bus_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d     = ST_REQ;
                    req_d       = 1'b1;
                    we_d        = mem_write && !mem_read;
                    addr_d      = alu_result;
                    wdata_d     = store_data;
                    hold_dir_d  = alu_result;
                    hold_load_d = mem_read;
                    hold_m2r_d  = mem_to_reg_in;
                    hold_rw_d   = reg_write_in;
                    hold_rd_d   = rd_in;
                end else if (valid_in) begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = '0;
                    wb_dir_d   = alu_result;
                    wb_m2r_d   = mem_to_reg_in;
                    wb_rw_d    = reg_write_in && !memop;
                    wb_rd_d    = rd_in;
                    mis_d      = memop;
                end
            end
            ST_REQ: begin
                if (dmem_ack || tc) begin
                    state_d    = ST_IDLE;
                    req_d      = 1'b0;
                    we_d       = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_dir_d   = hold_dir_q;
                    wb_m2r_d   = hold_m2r_q;
                    wb_rd_d    = hold_rd_q;
                    // An ack in the terminal cycle still completes normally.
                    if (dmem_ack) begin
                        wb_data_d = hold_load_q ? dmem_rdata : '0;
                        wb_rw_d   = hold_rw_q;
                    end else begin
                        wb_data_d = '0;
                        wb_rw_d   = 1'b0;
                        bus_d     = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            hold_dir_q  <= '0;
            hold_load_q <= 1'b0;
            hold_m2r_q  <= 1'b0;
            hold_rw_q   <= 1'b0;
            hold_rd_q   <= '0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= '0;
            wb_dir_q    <= '0;
            wb_m2r_q    <= 1'b0;
            wb_rw_q     <= 1'b0;
            wb_rd_q     <= '0;
            mis_q       <= 1'b0;
            bus_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            hold_dir_q  <= hold_dir_d;
            hold_load_q <= hold_load_d;
            hold_m2r_q  <= hold_m2r_d;
            hold_rw_q   <= hold_rw_d;
            hold_rd_q   <= hold_rd_d;
            wb_valid_q  <= wb_valid_d;
            wb_data_q   <= wb_data_d;
            wb_dir_q    <= wb_dir_d;
            wb_m2r_q    <= wb_m2r_d;
            wb_rw_q     <= wb_rw_d;
            wb_rd_q     <= wb_rd_d;
            mis_q       <= mis_d;
            bus_q       <= bus_d;
        end
    end

    assign dmem_req      = req_q;
    assign dmem_we       = we_q;
    assign dmem_addr     = addr_q;
    assign dmem_wdata    = wdata_q;
    assign wb_valid      = wb_valid_q;
    assign wb_data       = wb_data_q;
    assign wb_dir        = wb_dir_q;
    assign wb_mem_to_reg = wb_m2r_q;
    assign wb_reg_write  = wb_rw_q;
    assign wb_rd         = wb_rd_q;
    assign exc_misalign  = mis_q;
    assign exc_bus       = bus_q;

endmodule
